// File: rtl/soft_clock_stepper_if.sv
// Avalon-MM slave bus for the soft clock stepper register file (4 words).
// Handshake: a write takes effect on the rising clk edge where chipselect=1 and
// write_n=0; reads have zero wait states, readdata is combinational from address.
interface soft_clock_stepper_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/soft_clock_stepper.sv
// Turns rising edges of a software-written clock level into single-cycle nn_step
// pulses, tracks nn_done, buffers one early edge and reports status over Avalon-MM.
module soft_clock_stepper #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clock_in,
  input  logic                       nn_done,
  output logic                       nn_step,
  output logic                       busy,
  output logic                       state_dbg,
  soft_clock_stepper_if.slave        avs
);

  localparam logic [31:0] TIMEOUT_LIM = TIMEOUT_CYCLES;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        clock_in_d;
  logic        rise;
  logic        step_req;
  logic        start;
  logic        finish;
  logic        abort;
  logic        overrun_set;

  logic        enable;
  logic        pending;
  logic        overrun;
  logic        timeout;
  logic [31:0] step_count;
  logic [31:0] last_latency;
  logic [31:0] lat_cnt;

  logic        wr_en;
  logic        wr_ctrl;
  logic        wr_status;
  logic        clear;
  logic        unused_bits;

  assign rise     = clock_in & ~clock_in_d;
  assign step_req = rise & enable;

  assign wr_en     = avs.chipselect & ~avs.write_n;
  assign wr_ctrl   = wr_en & (avs.address == 2'd0);
  assign wr_status = wr_en & (avs.address == 2'd1);
  assign clear     = wr_ctrl & avs.writedata[1];

  // A second early edge while one is already buffered is lost.
  assign overrun_set = (state == S_WAIT) & step_req & pending;

  assign busy        = (state == S_WAIT);
  assign state_dbg   = state;
  assign unused_bits = &{1'b0, avs.writedata[31:4]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    case (state)
      S_IDLE: begin
        if (step_req | pending) begin
          state_next = S_WAIT;
          start      = 1'b1;
        end
      end
      S_WAIT: begin
        // Completion takes priority over a timeout landing on the same cycle.
        if (nn_done) begin
          state_next = S_IDLE;
          finish     = 1'b1;
        end else if (lat_cnt == TIMEOUT_LIM) begin
          state_next = S_IDLE;
          abort      = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clock_in_d   <= 1'b0;
      nn_step      <= 1'b0;
      lat_cnt      <= 32'd0;
      enable       <= 1'b1;
      pending      <= 1'b0;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
      step_count   <= 32'd0;
      last_latency <= 32'd0;
    end else begin
      clock_in_d <= clock_in;
      nn_step    <= start;

      if (start) begin
        lat_cnt <= 32'd1;
      end else if ((state == S_WAIT) && !finish && !abort) begin
        lat_cnt <= lat_cnt + 32'd1;
      end

      // In IDLE a pending edge is consumed by the start, unless a fresh edge refills it.
      if (state == S_IDLE) begin
        if (pending && !step_req) begin
          pending <= 1'b0;
        end
      end else if (step_req && !pending) begin
        pending <= 1'b1;
      end

      if (overrun_set) begin
        overrun <= 1'b1;
      end else if (wr_status && avs.writedata[2]) begin
        overrun <= 1'b0;
      end

      if (abort) begin
        timeout <= 1'b1;
      end else if (wr_status && avs.writedata[3]) begin
        timeout <= 1'b0;
      end

      if (wr_ctrl) begin
        enable <= avs.writedata[0];
      end

      if (clear) begin
        step_count   <= 32'd0;
        last_latency <= 32'd0;
      end else if (finish) begin
        step_count   <= step_count + 32'd1;
        last_latency <= lat_cnt;
      end
    end
  end

  always_comb begin
    avs.readdata = 32'd0;
    case (avs.address)
      2'd0:    avs.readdata = {31'd0, enable};
      2'd1:    avs.readdata = {28'd0, timeout, overrun, pending, busy};
      2'd2:    avs.readdata = step_count;
      2'd3:    avs.readdata = last_latency;
      default: avs.readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_soft_clock_stepper.sv
// Directed scenarios for soft_clock_stepper; expected step cycles and register
// reads are queued by the drivers and checked by an independent monitor.
module tb_soft_clock_stepper;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic clock_in = 1'b0;
  logic nn_done  = 1'b0;
  logic nn_step;
  logic busy;
  logic state_dbg;
  logic rd_valid = 1'b0;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  logic [31:0] step_q[$];
  logic [31:0] exp_q[$];
  logic [1:0]  rd_addr_q[$];

  soft_clock_stepper_if bus();

  soft_clock_stepper #(.TIMEOUT_CYCLES(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .clock_in  (clock_in),
    .nn_done   (nn_done),
    .nn_step   (nn_step),
    .busy      (busy),
    .state_dbg (state_dbg),
    .avs       (bus)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;
  end

  // driver tasks
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic rise_step();
    clock_in = 1'b1;
    step_q.push_back(32'(cyc + 1));
    next();
    clock_in = 1'b0;
  endtask

  task automatic rise_only();
    clock_in = 1'b1;
    next();
    clock_in = 1'b0;
    next();
  endtask

  task automatic do_done(input int delay);
    repeat (delay) next();
    nn_done = 1'b1;
    next();
    nn_done = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e);
    bus.address = a;
    rd_valid    = 1'b1;
    exp_q.push_back(e);
    rd_addr_q.push_back(a);
    next();
    rd_valid = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    next();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [31:0] e;
    logic [1:0]  a;
    if (nn_step) begin
      checks++;
      if (step_q.size() == 0) begin
        errors++;
        $display("FAIL step_unexpected: nn_step high at cycle %0d, no step expected", cyc);
      end else begin
        e = step_q.pop_front();
        if (e != 32'(cyc)) begin
          errors++;
          $display("FAIL step_cycle: nn_step at cycle %0d, expected cycle %0d", cyc, e);
        end
      end
    end else if (step_q.size() != 0 && step_q[0] < 32'(cyc)) begin
      checks++;
      errors++;
      e = step_q.pop_front();
      $display("FAIL step_missing: no nn_step by cycle %0d, expected at cycle %0d", cyc, e);
    end
    if (rd_valid) begin
      checks++;
      e = exp_q.pop_front();
      a = rd_addr_q.pop_front();
      if (bus.readdata !== e) begin
        errors++;
        $display("FAIL read_addr%0d: cycle %0d readdata 0x%08h, expected 0x%08h",
                 a, cyc, bus.readdata, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: stimulus did not complete by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    next();
    next();
    reset = 1'b0;

    // reset values
    rd(2'd0, 32'h1);
    rd(2'd1, 32'h0);
    rd(2'd2, 32'h0);
    rd(2'd3, 32'h0);

    // single step, done 5 cycles after the step
    rise_step();
    do_done(5);
    rd(2'd2, 32'd1);
    rd(2'd3, 32'd6);
    rd(2'd1, 32'h0);

    // pending and overrun: three rises during one WAIT
    wr(2'd0, 32'h3);
    rise_step();
    next();
    repeat (3) rise_only();
    nn_done = 1'b1;
    step_q.push_back(32'(cyc + 2));
    next();
    nn_done = 1'b0;
    rd(2'd1, 32'h6);
    do_done(1);
    rd(2'd2, 32'd2);
    rd(2'd3, 32'd2);
    rd(2'd1, 32'h4);
    wr(2'd1, 32'h4);
    rd(2'd1, 32'h0);

    // timeout after 8 busy cycles
    rise_step();
    repeat (7) next();
    rd(2'd1, 32'h1);
    rd(2'd1, 32'h8);
    rd(2'd2, 32'd2);
    rd(2'd3, 32'd2);
    wr(2'd1, 32'h8);
    rd(2'd1, 32'h0);
    rise_step();
    do_done(2);
    rd(2'd2, 32'd3);
    rd(2'd3, 32'd3);

    // enable off: rises ignored
    wr(2'd0, 32'h0);
    repeat (4) rise_only();
    rd(2'd1, 32'h0);
    rd(2'd0, 32'h0);
    wr(2'd0, 32'h1);

    // clear in the same cycle as a completing done
    rise_step();
    next();
    nn_done        = 1'b1;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = 2'd0;
    bus.writedata  = 32'h3;
    next();
    nn_done        = 1'b0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    rd(2'd2, 32'd0);
    rd(2'd3, 32'd0);
    rd(2'd0, 32'h1);

    // reset mid-WAIT, then a late done
    rise_step();
    do_done(0);
    rd(2'd2, 32'd1);
    rd(2'd3, 32'd1);
    rise_step();
    wr(2'd0, 32'h0);
    reset = 1'b1;
    next();
    reset   = 1'b0;
    nn_done = 1'b1;
    next();
    nn_done = 1'b0;
    rd(2'd0, 32'h1);
    rd(2'd1, 32'h0);
    rd(2'd2, 32'd0);
    rd(2'd3, 32'd0);

    // clock_in held high through reset gives one step after release
    clock_in = 1'b1;
    reset    = 1'b1;
    next();
    reset = 1'b0;
    step_q.push_back(32'(cyc + 1));
    next();
    do_done(0);
    next();
    clock_in = 1'b0;
    next();

    // nn_done tied high, rises two cycles apart
    wr(2'd0, 32'h3);
    nn_done = 1'b1;
    repeat (4) begin
      clock_in = 1'b1;
      step_q.push_back(32'(cyc + 1));
      next();
      clock_in = 1'b0;
      next();
    end
    nn_done = 1'b0;
    rd(2'd2, 32'd4);
    rd(2'd3, 32'd1);
    rd(2'd1, 32'h0);

    repeat (4) next();
    checks++;
    if (step_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: %0d steps and %0d reads still outstanding, expected 0",
               step_q.size(), exp_q.size());
    end

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
